// File: rtl/params.sv
// Shared types, AXI constants and the per-matrix burst-length table for the
// TRANS tile loader.
package params;

  typedef enum logic [1:0] {
    FP32 = 2'd0,
    FP16 = 2'd1,
    INT8 = 2'd2,
    INT4 = 2'd3
  } type_t;

  typedef enum logic [1:0] {
    RC_00 = 2'd0,
    RC_01 = 2'd1,
    RC_10 = 2'd2,
    RC_11 = 2'd3
  } rc_t;

  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR_A  = 3'd1,
    R_A   = 3'd2,
    AR_B  = 3'd3,
    R_B   = 3'd4,
    AR_C  = 3'd5,
    R_C   = 3'd6,
    FLUSH = 3'd7
  } load_state_t;

  localparam logic [2:0] AXI_SIZE_32B = 3'd5;
  localparam logic [1:0] AXI_INCR     = 2'b01;
  localparam logic [1:0] AXI_OKAY     = 2'b00;

  // Number of 32 B beats needed to move one tile of the given matrix.
  function automatic logic [6:0] beats(mat_t mat, type_t ty, rc_t rc);
    logic [6:0] n;
    n = 7'd32;
    case (mat)
      MAT_A: begin
        case (ty)
          FP32:    n = 7'd16;
          FP16:    n = 7'd8;
          INT8:    n = (rc == RC_00) ? 7'd64 : 7'd8;
          default: n = 7'd8;
        endcase
      end
      MAT_B:   n = (ty == FP32) ? 7'd8 : 7'd16;
      default: n = 7'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/trans_load_ctrl.sv
// Issues one AXI INCR read burst per matrix (A, B, optional C) and streams the
// returned beats straight into TRANS, pulsing done once the last write lands.
module trans_load_ctrl
  import params::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  type_t             cfg_type,
  input  rc_t               cfg_rc,
  input  logic              cfg_mixed,
  input  logic              cfg_load_c,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] t_data_in,
  output logic [5:0]        t_burst_num,
  output mat_t              t_mat,
  output type_t             t_type,
  output rc_t               t_rc,
  output logic              t_mixed,
  output logic              t_valid
);

  load_state_t       state_reg, state_next;
  logic [5:0]        cnt_reg, cnt_next;
  type_t             type_reg;
  rc_t               rc_reg;
  logic              mixed_reg;
  logic              load_c_reg;
  logic [ADDR_W-1:0] base_a_reg, base_b_reg, base_c_reg;
  logic              busy_reg, done_reg, err_reg;

  mat_t              cur_mat;
  logic [ADDR_W-1:0] ar_base;
  logic [6:0]        last_idx;
  logic              in_r;
  logic              beat;
  logic              is_final;

  always_comb begin
    cur_mat = MAT_A;
    ar_base = base_a_reg;
    case (state_reg)
      AR_B, R_B: begin
        cur_mat = MAT_B;
        ar_base = base_b_reg;
      end
      AR_C, R_C: begin
        cur_mat = MAT_C;
        ar_base = base_c_reg;
      end
      default: ;
    endcase
  end

  assign last_idx = beats(cur_mat, type_reg, rc_reg) - 7'd1;
  assign in_r     = (state_reg == R_A) || (state_reg == R_B) || (state_reg == R_C);
  assign beat     = in_r && m_rvalid;
  assign is_final = ({1'b0, cnt_reg} == last_idx);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_arlen     = '0;
    m_rready    = 1'b0;
    t_valid     = 1'b0;
    t_data_in   = '0;
    t_burst_num = '0;
    t_mat       = MAT_A;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (cfg_rc == RC_11) ? FLUSH : AR_A;
        end
      end
      AR_A, AR_B, AR_C: begin
        m_arvalid = 1'b1;
        m_araddr  = ar_base;
        m_arlen   = {1'b0, last_idx};
        if (m_arready) begin
          cnt_next = '0;
          case (state_reg)
            AR_A:    state_next = R_A;
            AR_B:    state_next = R_B;
            default: state_next = R_C;
          endcase
        end
      end
      R_A, R_B, R_C: begin
        m_rready = 1'b1;
        if (beat) begin
          t_valid     = 1'b1;
          t_data_in   = m_rdata;
          t_burst_num = cnt_reg;
          t_mat       = cur_mat;
          cnt_next    = cnt_reg + 6'd1;
          // The phase is closed by the beat count; m_rlast is only checked.
          if (is_final) begin
            case (state_reg)
              R_A:     state_next = AR_B;
              R_B:     state_next = load_c_reg ? AR_C : FLUSH;
              default: state_next = FLUSH;
            endcase
          end
        end
      end
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      type_reg   <= FP32;
      rc_reg     <= RC_00;
      mixed_reg  <= 1'b0;
      load_c_reg <= 1'b0;
      base_a_reg <= '0;
      base_b_reg <= '0;
      base_c_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= (state_reg == FLUSH);
      if (state_reg == IDLE && start) begin
        type_reg   <= cfg_type;
        rc_reg     <= cfg_rc;
        mixed_reg  <= cfg_mixed;
        load_c_reg <= cfg_load_c;
        base_a_reg <= base_a;
        base_b_reg <= base_b;
        base_c_reg <= base_c;
        busy_reg   <= 1'b1;
        err_reg    <= (cfg_rc == RC_11);
      end else begin
        if (state_reg == FLUSH) begin
          busy_reg <= 1'b0;
        end
        if (beat && ((m_rresp != AXI_OKAY) || (m_rlast != is_final))) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign m_arsize  = AXI_SIZE_32B;
  assign m_arburst = AXI_INCR;
  assign t_type    = type_reg;
  assign t_rc      = rc_reg;
  assign t_mixed   = mixed_reg;

endmodule

// File: tb/tb_trans_load_ctrl.sv
// Scoreboard bench for trans_load_ctrl: a small AXI read slave model feeds the
// DUT while a monitor checks every AR handshake and TRANS write against a queue.
module tb_trans_load_ctrl;
  import params::*;

  logic         clk = 1'b0;
  logic         rst, start;
  type_t        cfg_type;
  rc_t          cfg_rc;
  logic         cfg_mixed, cfg_load_c;
  logic [31:0]  base_a, base_b, base_c;
  logic         busy, done, err;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arvalid, m_arready;
  logic [255:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast, m_rvalid, m_rready;
  logic [255:0] t_data_in;
  logic [5:0]   t_burst_num;
  mat_t         t_mat;
  type_t        t_type;
  rc_t          t_rc;
  logic         t_mixed, t_valid;

  trans_load_ctrl #(.ADDR_W(32), .DATA_W(256)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_type(cfg_type), .cfg_rc(cfg_rc), .cfg_mixed(cfg_mixed), .cfg_load_c(cfg_load_c),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .busy(busy), .done(done), .err(err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .t_data_in(t_data_in), .t_burst_num(t_burst_num), .t_mat(t_mat), .t_type(t_type),
    .t_rc(t_rc), .t_mixed(t_mixed), .t_valid(t_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_exp_t;
  typedef struct packed { mat_t mat; logic [5:0] num; logic [31:0] addr; } beat_exp_t;

  ar_exp_t   ar_q[$];
  beat_exp_t beat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int beat_cnt = 0;
  bit sb_en = 1'b1;

  // slave knobs
  int ar_delay = 0;
  bit r_toggle = 1'b0;
  int bad_rlast_g = -1;
  int slverr_g = -1;

  function automatic logic [255:0] data_fn(input logic [31:0] addr, input logic [5:0] b);
    logic [31:0] w;
    w = addr ^ {26'h0, b} ^ {b, 26'h0} ^ 32'h5A3C_0F00;
    return {w, ~w, w, ~w, w, ~w, w, ~w};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI read slave: decides at mid-cycle, drives just after the rising edge.
  initial begin
    bit          ar_hs, r_hs, arv, rst_s, st;
    logic [31:0] hs_addr, s_addr;
    logic [7:0]  hs_len;
    int          ar_wait, s_len, s_beat, gbeat;
    bit          s_active, tog;
    ar_wait = 0; s_len = 1; s_beat = 0; gbeat = 0; s_active = 0; tog = 0; s_addr = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 0;
    forever begin
      @(negedge clk);
      ar_hs   = m_arvalid && m_arready;
      r_hs    = m_rvalid && m_rready;
      arv     = m_arvalid;
      rst_s   = rst;
      st      = start && !busy;
      hs_addr = m_araddr;
      hs_len  = m_arlen;
      @(posedge clk);
      #1;
      if (rst_s) begin
        s_active = 0;
        ar_wait  = 0;
      end else begin
        if (st) begin
          gbeat = 0;
          tog   = 0;
        end
        if (ar_hs) begin
          s_active = 1;
          s_len    = int'(hs_len) + 1;
          s_addr   = hs_addr;
          s_beat   = 0;
          ar_wait  = 0;
        end else if (arv) begin
          ar_wait++;
        end
        if (r_hs) begin
          s_beat++;
          gbeat++;
          if (s_beat == s_len) s_active = 0;
        end
        tog = ~tog;
      end
      m_arready = (ar_wait >= ar_delay);
      m_rvalid  = s_active && (!r_toggle || tog);
      m_rdata   = data_fn(s_addr, s_beat[5:0]);
      m_rlast   = (s_beat == s_len - 1) ^ (gbeat == bad_rlast_g);
      m_rresp   = (gbeat == slverr_g) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents AR or a TRANS write.
  initial begin
    ar_exp_t     e;
    beat_exp_t   b;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    prev_wait = 0; prev_addr = 0; prev_len = 0;
    forever begin
      @(negedge clk);
      if (sb_en && !rst) begin
        if (m_arvalid) begin
          if (prev_wait) begin
            chk("ar_stable_addr", m_araddr, prev_addr);
            chk("ar_stable_len", m_arlen, prev_len);
          end
          if (m_rready) fail("arvalid_in_r_state");
          if (m_arready) begin
            if (ar_q.size() == 0) fail("ar_unexpected");
            else begin
              e = ar_q.pop_front();
              chk("araddr", m_araddr, e.addr);
              chk("arlen", m_arlen, e.len);
              chk("arsize", m_arsize, 3'd5);
              chk("arburst", m_arburst, 2'b01);
            end
          end
        end
        prev_wait = m_arvalid && !m_arready;
        prev_addr = m_araddr;
        prev_len  = m_arlen;
        if (m_rready && !m_rvalid) chk("tvalid_idle", t_valid, 1'b0);
        if (t_valid) begin
          beat_cnt++;
          last_beat_cyc = cyc;
          if (beat_q.size() == 0) fail("beat_unexpected");
          else begin
            b = beat_q.pop_front();
            chk("t_mat", t_mat, b.mat);
            chk("t_burst_num", t_burst_num, b.num);
            chk("t_data_in", t_data_in, data_fn(b.addr, b.num));
          end
        end
      end else begin
        prev_wait = 0;
      end
    end
  end

  task automatic push_burst(input mat_t m, input logic [31:0] addr, input int len);
    ar_exp_t   e;
    beat_exp_t b;
    e.addr = addr;
    e.len  = len[7:0];
    ar_q.push_back(e);
    for (int i = 0; i <= len; i++) begin
      b.mat  = m;
      b.num  = i[5:0];
      b.addr = addr;
      beat_q.push_back(b);
    end
  endtask

  task automatic drive_start(input type_t ty, input rc_t rc, input logic lc,
                             input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
    @(posedge clk);
    #1;
    start = 1; cfg_type = ty; cfg_rc = rc; cfg_mixed = 1'b1; cfg_load_c = lc;
    base_a = ba; base_b = bb; base_c = bc;
  endtask

  int run_id = 0;

  task automatic run(input string name, input type_t ty, input rc_t rc, input logic lc,
                     input int len_a, input int len_b, input int len_c,
                     input logic exp_err, input bit poke);
    logic [31:0] ba, bb, bc;
    int total, s_cyc;
    bit got;
    run_id++;
    ba = 32'h1000_0000 + run_id * 32'h0001_0000;
    bb = ba + 32'h4000;
    bc = ba + 32'h8000;
    total = 0;
    if (len_a >= 0) begin push_burst(MAT_A, ba, len_a); total += len_a + 1; end
    if (len_b >= 0) begin push_burst(MAT_B, bb, len_b); total += len_b + 1; end
    if (len_c >= 0) begin push_burst(MAT_C, bc, len_c); total += len_c + 1; end
    beat_cnt = 0;
    drive_start(ty, rc, lc, ba, bb, bc);
    @(negedge clk);
    s_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0; cfg_type = INT8; cfg_rc = RC_01; cfg_mixed = 0; cfg_load_c = ~lc;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
    chk("err_on_start", err, rc == RC_11);
    chk("t_type_latched", t_type, ty);
    chk("t_rc_latched", t_rc, rc);
    chk("t_mixed_latched", t_mixed, 1'b1);
    if (poke) begin
      repeat (12) @(posedge clk);
      #1;
      start = 1; cfg_type = INT8; cfg_rc = RC_00; base_a = 32'h0; base_b = 32'h0; cfg_load_c = 0;
      @(posedge clk);
      #1;
      start = 0;
    end
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) fail({name, "_done_timeout"});
    else begin
      if (total > 0) chk("done_latency", cyc - last_beat_cyc, 2);
      else           chk("done_latency", cyc - s_cyc, 2);
      chk("busy_at_done", busy, 1'b0);
    end
    chk("beat_count", beat_cnt, total);
    chk("ar_q_left", ar_q.size(), 0);
    chk("beat_q_left", beat_q.size(), 0);
    chk("err_final", err, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    $display("run %0d %s: beats=%0d err=%0b", run_id, name, beat_cnt, err);
    ar_q.delete();
    beat_q.delete();
  endtask

  initial begin
    bit seen;
    rst = 1; start = 0; cfg_type = FP32; cfg_rc = RC_00; cfg_mixed = 0; cfg_load_c = 0;
    base_a = 0; base_b = 0; base_c = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("rst_tvalid", t_valid, 1'b0);
    chk("rst_burst_num", t_burst_num, 6'd0);
    chk("rst_t_mat", t_mat, MAT_A);

    run("fp32_abc", FP32, RC_00, 1'b1, 15, 7, 31, 1'b0, 1'b0);
    run("int8_ab", INT8, RC_00, 1'b0, 63, 15, -1, 1'b0, 1'b0);

    ar_delay = 5; r_toggle = 1'b1;
    run("fp16_slow", FP16, RC_01, 1'b1, 7, 15, 31, 1'b0, 1'b1);
    ar_delay = 0; r_toggle = 1'b0;

    bad_rlast_g = 3;
    run("rlast_err", FP16, RC_00, 1'b0, 7, 15, -1, 1'b1, 1'b0);
    bad_rlast_g = -1;

    slverr_g = 18;
    run("slverr_b", FP32, RC_00, 1'b0, 15, 7, -1, 1'b1, 1'b0);
    slverr_g = -1;
    run("err_clear", INT8, RC_01, 1'b0, 7, 15, -1, 1'b0, 1'b0);

    // abort a run inside the B phase
    sb_en = 0;
    drive_start(FP32, RC_00, 1'b1, 32'h2000_0000, 32'h2000_4000, 32'h2000_8000);
    @(posedge clk);
    #1;
    start = 0;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (t_valid && t_mat == MAT_B) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail("reach_r_b_timeout");
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_arvalid", m_arvalid, 1'b0);
    chk("midrst_rready", m_rready, 1'b0);
    chk("midrst_tvalid", t_valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    ar_q.delete();
    beat_q.delete();
    sb_en = 1;
    run("int4_after_rst", INT4, RC_10, 1'b1, 7, 15, 31, 1'b0, 1'b0);

    run("bad_rc", FP32, RC_11, 1'b1, -1, -1, -1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trans_load_ctrl.md
Name: trans_load_ctrl

Overview:
- Sequences tile loads from AXI memory into the TRANS operand-formatting stage.
- On each start it issues one AXI INCR read burst per matrix, in the order A, B, then optionally C.
- It drives TRANS with data_in, burst_num, mat, valid and the latched data_type, rc and mixed values.
- It pulses done once the last formatted write has left TRANS's output register.

Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 256: AXI read data width; fixed to match TRANS data_in.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle request; accepted only in IDLE.
- cfg_type  in  params::type_t: operand type, latched on accepted start.
- cfg_rc  in  params::rc_t: tile shape, latched on start.
- cfg_mixed  in  1: mixed-precision flag, latched on start.
- cfg_load_c  in  1: 1 = load C; 0 = skip the C phase. Latched on start.
- base_a, base_b, base_c  in  ADDR_W: byte base addresses, latched on start.
- busy  out  1: high from accepted start until done.
- done  out  1: one-cycle completion pulse.
- err  out  1: sticky error flag; cleared on the next accepted start.
- m_araddr  out  ADDR_W: AR address.
- m_arlen  out  8: AR burst length minus 1.
- m_arsize  out  3: constant 3'd5 (32 B).
- m_arburst  out  2: constant INCR (2'b01).
- m_arvalid  out  1: AR valid.
- m_arready  in  1: AR ready.
- m_rdata  in  DATA_W: read data.
- m_rresp  in  2: read response.
- m_rlast  in  1: last beat of burst.
- m_rvalid  in  1: R valid.
- m_rready  out  1: R ready.
- t_data_in  out  DATA_W: data to TRANS.
- t_burst_num  out  6: beat index to TRANS.
- t_mat  out  params::mat_t: matrix select to TRANS.
- t_type  out  params::type_t: latched type to TRANS.
- t_rc  out  params::rc_t: latched shape to TRANS.
- t_mixed  out  1: latched mixed flag to TRANS.
- t_valid  out  1: write strobe to TRANS.

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, done, err, m_arvalid, m_rready, t_valid = 0.
  - t_burst_num = 0; t_mat = A; all other outputs 0.
- States: IDLE, AR_A, R_A, AR_B, R_B, AR_C, R_C, FLUSH.
- IDLE: start=1 latches all cfg_*/base_* inputs, clears err, moves to AR_A, and sets busy the next cycle.
- AR_x state:
  - m_arvalid=1, m_araddr=base_x, m_arlen=beats(x)-1.
  - Fields stay stable until m_arready. The handshake cycle moves to R_x and resets the beat counter to 0.
- R_x state: m_rready=1. Each cycle with m_rvalid&&m_rready (beat):
  - t_valid=1, t_data_in=m_rdata, t_burst_num=counter, t_mat=x. These are combinational passthroughs, zero added latency.
  - counter increments.
- Beat counts (package function beats(mat,type,rc)):
  - A: FP32 16; FP16 8; INT8 rc00 64; INT8 rc01/rc10 8; INT4 8.
  - B: FP32 8; all other types 16.
  - C: 32 for every type/rc/mixed combination.
- Phase end: the beat where counter==beats(x)-1.
  - A ends → AR_B.
  - B ends → AR_C if load_c, else FLUSH.
  - C ends → FLUSH.
- m_rlast checking: a mismatch sets err. Mismatch means m_rlast=1 on a non-final beat, or m_rlast=0 on the final beat. The phase still ends on the count, not on m_rlast.
- Any beat with m_rresp != OKAY sets err; the beat is still forwarded.
- FLUSH: lasts 1 cycle so TRANS's registered write lands. Then done=1 for one cycle, busy=0, state=IDLE.
  - Latency: done is asserted 2 cycles after the final beat handshake.
- Only one burst is outstanding at any time; m_arvalid is never high in an R state.
- start while busy is ignored; the latched config is unchanged.
- rst mid-operation: next cycle is IDLE with all handshake outputs low. Any outstanding R beats are the system's responsibility (interconnect reset).
- Invalid rc (2'b11) at start: err set, no bursts issued, done pulsed 1 cycle later via FLUSH.

Decomposition:
- params package gains:
  - function beats(mat_t, type_t, rc_t) returning logic [6:0].
  - localparams for AXI_SIZE_32B and AXI_INCR.
  - enum load_state_t.
- No sub-module; the beat counter and FSM live in one always_ff/always_comb pair.

Test Plan:
- FP32, rc00, load_c=1, arready/rvalid always 1:
  - AR lens observed in order 15, 7, 31.
  - 56 t_valid pulses.
  - t_burst_num runs 0..15 (A), 0..7 (B), 0..31 (C).
  - done exactly 2 cycles after the last beat.
- INT8 rc00, load_c=0 → arlen 63 then 15, no C burst, done after 80 beats, err=0.
- m_arready delayed 5 cycles and m_rvalid toggled 1/0 → m_araddr/m_arlen stable while waiting, no t_valid on idle cycles, burst_num contiguous.
- m_rlast asserted on beat 3 of an A FP16 burst → err=1; controller still consumes 8 beats and completes.
- m_rresp=SLVERR on one B beat → err=1 sticky, data forwarded; next start clears err.
- rst asserted during R_B, then start with INT4 rc10 → clean IDLE after reset; new run gives lens 7, 15, 31 and done.
